// File: rtl/alex_pkg.sv
// Shared types and constants for the Alex filter-board serial transmitter.
// Pure declarations: no latency, no flow control.
package alex_pkg;

   localparam int ALEX_WORD_W = 16;
   localparam int LPF_MSB     = 15;
   localparam int LPF_LSB     = 9;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD,
      GAP
   } alex_state_t;

   function automatic logic [LPF_MSB-LPF_LSB:0] lpf_field(input logic [ALEX_WORD_W-1:0] word);
      return word[LPF_MSB:LPF_LSB];
   endfunction

endpackage

// File: rtl/alex_spi_shifter.sv
// Bit engine: shifts one word MSB-first, CLK_DIV clocks low then CLK_DIV clocks high per bit.
// Word takes 32*CLK_DIV clocks after i_start; o_done marks the last clock of bit 0; start is never refused.
module alex_spi_shifter
   import alex_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [ALEX_WORD_W-1:0] i_word,
   output logic                   o_spi_clock,
   output logic                   o_spi_data,
   output logic                   o_done
);

   logic [ALEX_WORD_W-1:0] r_shift;
   logic [15:0]            r_div;
   logic [3:0]             r_bit;
   logic                   r_phase;
   logic                   r_active;
   logic                   w_div_end;

   assign w_div_end   = (r_div == 16'(CLK_DIV - 1));
   assign o_done      = r_active & r_phase & w_div_end & (r_bit == 4'd0);
   assign o_spi_clock = r_active & r_phase;
   assign o_spi_data  = r_active & r_shift[ALEX_WORD_W-1];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_shift  <= '0;
         r_div    <= '0;
         r_bit    <= '0;
         r_phase  <= 1'b0;
         r_active <= 1'b0;
      end else if (i_start) begin
         r_shift  <= i_word;
         r_div    <= '0;
         r_bit    <= 4'(ALEX_WORD_W - 1);
         r_phase  <= 1'b0;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (w_div_end) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
            // data only moves at the end of the high phase, so it is stable across the rising edge
            if (r_phase) begin
               r_shift <= {r_shift[ALEX_WORD_W-2:0], 1'b0};
               r_bit   <= r_bit - 4'd1;
               if (r_bit == 4'd0)
                  r_active <= 1'b0;
            end
         end else begin
            r_div <= r_div + 16'd1;
         end
      end
   end

endmodule

// File: rtl/alex_spi_tx.sv
// Alex TX/RX filter-word serialiser; sends each word after reset and on change (optional ALEX_REFRESH_EN periodic resend).
// First bit one clock after a pending word is seen; word+load = 33*CLK_DIV clocks, then GAP_CYCLES idle; no input backpressure.
module alex_spi_tx
   import alex_pkg::*;
#(
   parameter int CLK_DIV     = 8,
   parameter int GAP_CYCLES  = 16,
   parameter int REFRESH_CYC = 1000000
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [ALEX_WORD_W-1:0] i_tx_word,
   input  logic [ALEX_WORD_W-1:0] i_rx_word,
   output logic                   o_spi_clock,
   output logic                   o_spi_data,
   output logic                   o_tx_load,
   output logic                   o_rx_load,
   output logic                   o_busy
);

   alex_state_t            r_state;
   alex_state_t            w_state_nxt;
   logic                   r_sel;
   logic                   w_sel_nxt;
   logic [15:0]            r_cnt;
   logic [15:0]            w_cnt_nxt;
   logic [ALEX_WORD_W-1:0] r_tx_shadow;
   logic [ALEX_WORD_W-1:0] r_rx_shadow;
   logic                   r_tx_force;
   logic                   r_rx_force;
   logic                   w_tx_pend;
   logic                   w_rx_pend;
   logic                   w_start;
   logic                   w_start_rx;
   logic                   w_done;
   logic                   w_refresh;

   // A change that reverts before the word starts leaves nothing to send.
   assign w_tx_pend = r_tx_force | (i_tx_word != r_tx_shadow);
   assign w_rx_pend = r_rx_force | (i_rx_word != r_rx_shadow);

`ifdef ALEX_REFRESH_EN
   logic [31:0] r_refresh;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_refresh <= '0;
      else if (w_refresh)
         r_refresh <= '0;
      else
         r_refresh <= r_refresh + 32'd1;
   end

   assign w_refresh = (r_refresh == 32'(REFRESH_CYC - 1));
`else
   // only an invalid (negative) period could request a resend in this build
   assign w_refresh = (REFRESH_CYC < 0);
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_tx_shadow <= '0;
         r_rx_shadow <= '0;
         r_tx_force  <= 1'b1;
         r_rx_force  <= 1'b1;
      end else begin
         if (w_start && !w_start_rx) begin
            r_tx_shadow <= i_tx_word;
            r_tx_force  <= 1'b0;
         end
         if (w_start && w_start_rx) begin
            r_rx_shadow <= i_rx_word;
            r_rx_force  <= 1'b0;
         end
         if (w_refresh) begin
            r_tx_force <= 1'b1;
            r_rx_force <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_sel   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_start_rx  = 1'b0;
      o_tx_load   = 1'b0;
      o_rx_load   = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (w_tx_pend || w_rx_pend) begin
               w_start     = 1'b1;
               w_start_rx  = ~w_tx_pend;
               w_sel_nxt   = ~w_tx_pend;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_done) begin
               w_cnt_nxt   = '0;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            o_tx_load = ~r_sel;
            o_rx_load = r_sel;
            if (r_cnt == 16'(CLK_DIV - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = GAP;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         GAP: begin
            if (r_cnt == 16'(GAP_CYCLES - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   alex_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_start     (w_start),
      .i_word      (w_start_rx ? i_rx_word : i_tx_word),
      .o_spi_clock (o_spi_clock),
      .o_spi_data  (o_spi_data),
      .o_done      (w_done)
   );

endmodule

// File: tb/tb_alex_spi_tx.sv
// Directed + randomized bench for alex_spi_tx: frames decoded from the pins and compared with a send-on-change model.
module tb_alex_spi_tx;

   localparam int CLK_DIV     = 2;
   localparam int GAP_CYCLES  = 4;
   localparam int REFRESH_CYC = 500;
   localparam int WORD_CYC    = 33 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] tx_word = 16'h0000;
   logic [15:0] rx_word = 16'h0000;
   logic        spi_clock, spi_data, tx_load, rx_load, busy;

   int n_cmp = 0;
   int n_err = 0;

   alex_spi_tx #(
      .CLK_DIV     (CLK_DIV),
      .GAP_CYCLES  (GAP_CYCLES),
      .REFRESH_CYC (REFRESH_CYC)
   ) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_tx_word   (tx_word),
      .i_rx_word   (rx_word),
      .o_spi_clock (spi_clock),
      .o_spi_data  (spi_data),
      .o_tx_load   (tx_load),
      .o_rx_load   (rx_load),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_rx;
      logic [15:0] word;
      int          nbits;
      int          span;
      int          ld_len;
   } frm_t;

   frm_t        cap_q[$];
   int          gap_q[$];
   bit          exp_rx[$];
   logic [15:0] exp_word[$];
   logic [15:0] sh_tx, sh_rx;
   logic [15:0] last_tx, last_rx;
   int          viol_both = 0;
   int          viol_sclk = 0;

   // pin-level frame decoder, sampled on the falling edge
   int          cyc = 0;
   logic [15:0] m_bits;
   int          m_nb = 0, m_start = 0, m_ld = 0, m_gap = 0;
   bit          busy_p = 0, sclk_p = 0, ld_p = 0, in_gap = 0, cur_rx = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_nb = 0; m_bits = '0; busy_p = 0; sclk_p = 0; ld_p = 0; in_gap = 0; m_ld = 0;
      end else begin
         if (tx_load && rx_load) viol_both++;
         if (spi_clock && (!busy || tx_load || rx_load)) viol_sclk++;
         if (busy && !busy_p) begin m_start = cyc; m_nb = 0; end
         if (spi_clock && !sclk_p) begin m_bits = {m_bits[14:0], spi_data}; m_nb++; end
         if ((tx_load || rx_load) && !ld_p) begin m_ld = 0; cur_rx = rx_load; end
         if (tx_load || rx_load) m_ld++;
         if (!(tx_load || rx_load) && ld_p) begin
            cap_q.push_back('{cur_rx, m_bits, m_nb, cyc - m_start, m_ld});
            in_gap = 1; m_gap = 0;
         end
         if (in_gap) begin
            if (busy) m_gap++;
            else begin gap_q.push_back(m_gap); in_gap = 0; end
         end
         busy_p = busy; sclk_p = spi_clock; ld_p = tx_load || rx_load;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply new words while idle; model: a word is sent iff it differs from the last one sent, TX first.
   task automatic apply(input logic [15:0] t, input logic [15:0] r);
      @(posedge clk); #1;
      tx_word = t; rx_word = r;
      if (t != sh_tx) begin exp_rx.push_back(0); exp_word.push_back(t); sh_tx = t; end
      if (r != sh_rx) begin exp_rx.push_back(1); exp_word.push_back(r); sh_rx = r; end
   endtask

   task automatic wait_quiet();
      int q = 0, t = 0;
      while (q < 8 && t < 5000) begin
         @(negedge clk); t++;
         q = busy ? 0 : q + 1;
      end
      chk("quiet_timeout", 32'(q >= 8), 32'd1);
   endtask

   task automatic wait_busy_rise();
      int t = 0;
      while (!busy && t < 200) begin @(negedge clk); t++; end
      chk("busy_rise_timeout", 32'(busy), 32'd1);
   endtask

   task automatic drop_dups();
`ifdef ALEX_REFRESH_EN
      while (cap_q.size() > 0 && cap_q[0].word === (cap_q[0].is_rx ? last_rx : last_tx)) begin
         void'(cap_q.pop_front());
         if (gap_q.size() > 0) void'(gap_q.pop_front());
      end
`endif
   endtask

   task automatic check_frames(input string tag);
      frm_t f;
      int   g;
      while (exp_rx.size() > 0) begin
         drop_dups();
         if (cap_q.size() == 0) begin
            chk({tag, "_missing"}, 32'(cap_q.size()), 32'(exp_rx.size()));
            exp_rx.delete(); exp_word.delete();
            break;
         end
         f = cap_q.pop_front();
         g = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
         chk({tag, "_kind"},  32'(f.is_rx), 32'(exp_rx[0]));
         chk({tag, "_word"},  32'(f.word),  32'(exp_word[0]));
         chk({tag, "_nbits"}, f.nbits,      32'd16);
         chk({tag, "_span"},  f.span,       WORD_CYC);
         chk({tag, "_load"},  f.ld_len,     CLK_DIV);
         chk({tag, "_gap"},   g,            GAP_CYCLES);
         if (f.is_rx) last_rx = f.word; else last_tx = f.word;
         void'(exp_rx.pop_front());
         void'(exp_word.pop_front());
      end
      drop_dups();
      chk({tag, "_extra"}, 32'(cap_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] nt, nr;
      int ntx, nrx, nbad;

      // reset state
      tx_word = 16'h1234; rx_word = 16'h00A5;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {27'd0, spi_clock, spi_data, tx_load, rx_load, busy}, 32'd0);
      sh_tx = 16'h0000; sh_rx = 16'h0000;
      last_tx = 'x; last_rx = 'x;
      exp_rx.push_back(0); exp_word.push_back(16'h1234);
      exp_rx.push_back(1); exp_word.push_back(16'h00A5);
      sh_tx = 16'h1234; sh_rx = 16'h00A5;
      rst = 1'b0;
      wait_quiet();
      check_frames("post_reset");
      chk("idle_busy", 32'(busy), 32'd0);

      // single RX change
      apply(sh_tx, 16'h8001);
      wait_quiet();
      check_frames("rx_8001");

      // both words change in the same clock: TX first
      nt = 16'($urandom) | 16'h8000;
      nr = 16'($urandom) & 16'h7FFE;
      apply(nt, nr);
      wait_quiet();
      check_frames("both_change");

      // TX change while a TX word is in flight
      apply(16'h0001, sh_rx);
      wait_busy_rise();
      repeat (10) @(negedge clk);
      tx_word = 16'h0002;
      exp_rx.push_back(0); exp_word.push_back(16'h0002); sh_tx = 16'h0002;
      wait_quiet();
      check_frames("mid_shift");

      // randomized changes against the send-on-change model
      for (int i = 0; i < 12; i++) begin
         nt = ($urandom_range(0, 1) != 0) ? 16'($urandom) : sh_tx;
         nr = ($urandom_range(0, 1) != 0) ? 16'($urandom) : sh_rx;
         apply(nt, nr);
         wait_quiet();
         check_frames("random");
      end

      // reset during bit 7 of a TX word
      nt = 16'($urandom);
      if (nt == sh_tx) nt = ~nt;
      @(posedge clk); #1;
      tx_word = nt;
      wait_busy_rise();
      repeat (33) @(negedge clk);
      chk("abort_bits_sent", m_nb, 32'd8);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {27'd0, spi_clock, spi_data, tx_load, rx_load, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_rx.push_back(0); exp_word.push_back(nt);
      exp_rx.push_back(1); exp_word.push_back(rx_word);
      sh_tx = nt; sh_rx = rx_word;
      last_tx = 'x; last_rx = 'x;
      wait_quiet();
      check_frames("after_abort");

      // static words: periodic resend only when refresh is built in
      cap_q.delete(); gap_q.delete();
      repeat (1200) @(negedge clk);
      wait_quiet();
`ifdef ALEX_REFRESH_EN
      ntx = 0; nrx = 0; nbad = 0;
      foreach (cap_q[k]) begin
         if (cap_q[k].is_rx) begin nrx++; if (cap_q[k].word !== sh_rx) nbad++; end
         else begin ntx++; if (cap_q[k].word !== sh_tx) nbad++; end
      end
      chk("refresh_tx_count", 32'(ntx >= 2 && ntx <= 3), 32'd1);
      chk("refresh_rx_count", nrx, ntx);
      chk("refresh_words", nbad, 32'd0);
`else
      ntx = 0; nrx = 0; nbad = 0;
      chk("no_refresh_frames", 32'(cap_q.size()), 32'd0);
`endif

      chk("both_loads_high", viol_both, 32'd0);
      chk("stray_spi_clock", viol_sclk, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
